bsg_counter_set_en_sched: RTL and testbench

- Round-robin scheduler that shares one settable up-counter (set/enable counter datapath, held internally) among els_p requesters.
- Each requester asks for a timed interval of N ticks. The scheduler grants one requester at a time, clears and enables the counter, counts to N, then reports completion with the winner's id.
- Sits between client timeout/delay users and the shared count resource. count_o is exported for debug and observation.

---
 rtl/bsg_counter_set_en_sched.sv | 138 +++++++++++++
 tb/tb_bsg_counter_set_en_sched.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_counter_set_en_sched.sv
// Round-robin scheduler sharing one settable up-counter among els_p requesters.
// Each grant clears the counter, counts to the requested interval, then reports done with the winner's id.
module bsg_counter_set_en_sched #(
  parameter int unsigned els_p     = 4,
  parameter int unsigned max_val_p = 1000,
  parameter int unsigned width_p   = $clog2(max_val_p + 1),
  localparam int unsigned lg_els_lp = $clog2(els_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [els_p-1:0]           req_v_i,
  input  logic [els_p*width_p-1:0]   req_val_i,
  output logic [els_p-1:0]           req_yumi_o,
  input  logic                       pause_i,
  input  logic                       abort_i,
  output logic                       busy_o,
  output logic [width_p-1:0]         count_o,
  output logic                       done_v_o,
  output logic [lg_els_lp-1:0]       done_id_o,
  input  logic                       done_ready_i
);

  localparam logic [1:0] st_idle = 2'd0;
  localparam logic [1:0] st_run  = 2'd1;
  localparam logic [1:0] st_done = 2'd2;

  localparam logic [width_p-1:0] max_val_lp = width_p'(max_val_p);

  logic [1:0]           state_r, state_n;
  logic [width_p-1:0]   count_r;
  logic [width_p-1:0]   target_r, target_n;
  logic [lg_els_lp-1:0] id_r, id_n;
  logic [lg_els_lp-1:0] rr_r, rr_n;
  logic                 busy_r, done_v_r;

  logic                 count_set_c, count_en_c;
  logic                 any_c;
  logic [lg_els_lp-1:0] win_c;
  logic [width_p-1:0]   slot_c;
  logic [els_p-1:0]     yumi_c;
  int unsigned          cand_c;
  int unsigned          base_c;

  // First valid requester at or after the rr pointer, wrapping at els_p.
  always_comb begin
    any_c  = 1'b0;
    win_c  = '0;
    cand_c = 0;
    for (int unsigned i = 0; i < els_p; i++) begin
      cand_c = (32'(rr_r) + i) % els_p;
      if (!any_c && req_v_i[lg_els_lp'(cand_c)]) begin
        any_c = 1'b1;
        win_c = lg_els_lp'(cand_c);
      end
    end
    base_c = 32'(win_c) * width_p;
    slot_c = req_val_i[base_c +: width_p];
  end

  // Next-state, counter controls and grant.
  always_comb begin
    state_n     = state_r;
    target_n    = target_r;
    id_n        = id_r;
    rr_n        = rr_r;
    count_set_c = 1'b0;
    count_en_c  = 1'b0;
    yumi_c      = '0;
    unique case (state_r)
      st_idle: begin
        if (any_c) begin
          yumi_c      = els_p'(1) << win_c;
          id_n        = win_c;
          target_n    = (slot_c > max_val_lp) ? max_val_lp : slot_c;
          count_set_c = 1'b1;
          rr_n        = (32'(win_c) == els_p - 1) ? '0 : win_c + lg_els_lp'(1);
          state_n     = st_run;
        end
      end
      st_run: begin
        if (abort_i) begin
          count_set_c = 1'b1;
          state_n     = st_idle;
        end else if (count_r == target_r) begin
          state_n = st_done;
        end else if (!pause_i) begin
          count_en_c = 1'b1;
        end
      end
      st_done: begin
        if (abort_i || done_ready_i) begin
          count_set_c = 1'b1;
          state_n     = st_idle;
        end
      end
      default: begin
        count_set_c = 1'b1;
        state_n     = st_idle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r  <= st_idle;
      target_r <= '0;
      id_r     <= '0;
      rr_r     <= '0;
      busy_r   <= 1'b0;
      done_v_r <= 1'b0;
    end else begin
      state_r  <= state_n;
      target_r <= target_n;
      id_r     <= id_n;
      rr_r     <= rr_n;
      busy_r   <= (state_n != st_idle);
      done_v_r <= (state_n == st_done);
    end
  end

  // Shared counter datapath: set wins over enable.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_r <= '0;
    end else if (count_set_c) begin
      count_r <= '0;
    end else if (count_en_c) begin
      count_r <= count_r + width_p'(1);
    end
  end

  assign req_yumi_o = yumi_c;
  assign busy_o     = busy_r;
  assign done_v_o   = done_v_r;
  assign done_id_o  = id_r;
  assign count_o    = count_r;

endmodule

// File: tb/tb_bsg_counter_set_en_sched.sv
// Directed bench for bsg_counter_set_en_sched: expected done id/cycle queued at grant, checked at done.
module tb_bsg_counter_set_en_sched;

  localparam int unsigned els_p   = 4;
  localparam int unsigned width_p = 10;

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b0;
  logic [els_p-1:0]         req_v = '0;
  logic [els_p*width_p-1:0] req_val = '0;
  logic [els_p-1:0]         req_yumi;
  logic                     pause = 1'b0;
  logic                     abort = 1'b0;
  logic                     busy;
  logic [width_p-1:0]       count;
  logic                     done_v;
  logic [1:0]               done_id;
  logic                     done_ready = 1'b1;

  typedef struct {
    int id;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  bsg_counter_set_en_sched #(.els_p(4), .max_val_p(1000)) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .req_v_i      (req_v),
    .req_val_i    (req_val),
    .req_yumi_o   (req_yumi),
    .pause_i      (pause),
    .abort_i      (abort),
    .busy_o       (busy),
    .count_o      (count),
    .done_v_o     (done_v),
    .done_id_o    (done_id),
    .done_ready_i (done_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_slot(input int idx, input int val);
    req_val[idx*width_p +: width_p] = width_p'(val);
  endtask

  // Wait (bounded) for done, then pop the scoreboard and check id and arrival cycle.
  task automatic wait_done(input string tag, input int budget);
    exp_t e;
    int   n;
    n = 0;
    while (done_v !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_done_v"}, 32'(done_v), 1);
    chk({tag, "_sb_depth"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_done_id"}, 32'(done_id), e.id);
      chk({tag, "_done_cyc"}, cyc, e.cyc);
    end
  endtask

  initial begin
    int g;
    int maxc;
    int n;

    // Reset values
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done_v", 32'(done_v), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_yumi", 32'(req_yumi), 0);
    chk("rst_done_id", 32'(done_id), 0);
    step();
    reset_n = 1'b1;

    // Single request, interval 3
    req_v = 4'b0001;
    set_slot(0, 3);
    #1;
    chk("t1_yumi", 32'(req_yumi), 1);
    g = cyc;
    sb.push_back('{0, g + 5});
    step();
    req_v = '0;
    for (int j = 0; j < 4; j++) begin
      chk("t1_count", 32'(count), j);
      if (j < 3) step();
    end
    step();
    wait_done("t1", 5);
    step();
    chk("t1_idle_busy", 32'(busy), 0);

    // Reset pulse, then round-robin with all requesters held and zero intervals
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    req_val = '0;
    req_v   = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("t2_yumi", 32'(req_yumi), 32'(1) << (k % 4));
      sb.push_back('{k % 4, cyc + 2});
      step();
      chk("t2_yumi_run", 32'(req_yumi), 0);
      chk("t2_busy", 32'(busy), 1);
      step();
      wait_done("t2", 0);
      if (k == 4) req_v = '0;
      step();
    end

    // Interval above max clamps to 1000
    req_v = 4'b0100;
    set_slot(2, 1023);
    #1;
    chk("t3_yumi", 32'(req_yumi), 4);
    sb.push_back('{2, cyc + 1002});
    step();
    req_v = '0;
    maxc = 0;
    n = 0;
    while (done_v !== 1'b1 && n < 1100) begin
      if (int'(count) > maxc) maxc = int'(count);
      step();
      n++;
    end
    chk("t3_max_count", maxc, 1000);
    wait_done("t3", 0);
    chk("t3_count_hold", 32'(count), 1000);
    step();
    chk("t3_idle_busy", 32'(busy), 0);

    // Interval 5 with three paused cycles; rr wraps from 3 to requester 1
    req_val = '0;
    req_v   = 4'b0010;
    set_slot(1, 5);
    done_ready = 1'b0;
    #1;
    chk("t4_yumi", 32'(req_yumi), 2);
    sb.push_back('{1, cyc + 10});
    step();
    req_v = '0;
    chk("t4_count0", 32'(count), 0);
    step();
    chk("t4_count1", 32'(count), 1);
    step();
    chk("t4_count2", 32'(count), 2);
    pause = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      chk("t4_frozen", 32'(count), 2);
    end
    pause = 1'b0;
    wait_done("t4", 6);
    for (int j = 0; j < 5; j++) begin
      chk("t4_hold_v", 32'(done_v), 1);
      chk("t4_hold_id", 32'(done_id), 1);
      chk("t4_hold_count", 32'(count), 5);
      step();
    end
    done_ready = 1'b1;
    step();
    chk("t4_idle_busy", 32'(busy), 0);
    chk("t4_idle_done_v", 32'(done_v), 0);

    // Abort during RUN at count 4
    req_val = '0;
    req_v   = 4'b0100;
    set_slot(2, 10);
    #1;
    chk("t5_yumi", 32'(req_yumi), 4);
    for (int j = 0; j < 5; j++) step();
    req_v = '0;
    chk("t5_count4", 32'(count), 4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_abort_busy", 32'(busy), 0);
    chk("t5_abort_count", 32'(count), 0);
    for (int j = 0; j < 4; j++) begin
      chk("t5_no_done", 32'(done_v), 0);
      step();
    end

    // Abort in DONE while consumer not ready
    req_v = 4'b1000;
    set_slot(3, 1);
    done_ready = 1'b0;
    #1;
    chk("t5b_yumi", 32'(req_yumi), 8);
    sb.push_back('{3, cyc + 3});
    step();
    req_v = '0;
    wait_done("t5b", 4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    done_ready = 1'b1;
    chk("t5b_done_v", 32'(done_v), 0);
    chk("t5b_busy", 32'(busy), 0);
    chk("t5b_count", 32'(count), 0);

    // Async reset mid-RUN at count 7; rr pointer must return to 0
    req_val = '0;
    req_v   = 4'b0001;
    set_slot(0, 20);
    #1;
    chk("t6_yumi", 32'(req_yumi), 1);
    step();
    req_v = '0;
    for (int j = 0; j < 7; j++) step();
    chk("t6_count7", 32'(count), 7);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_count", 32'(count), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_done_v", 32'(done_v), 0);
    step();
    reset_n = 1'b1;
    req_val = '0;
    req_v   = 4'b0011;
    #1;
    chk("t6_rr_reset", 32'(req_yumi), 1);
    sb.push_back('{0, cyc + 2});
    step();
    req_v = '0;
    wait_done("t6", 3);
    step();
    chk("t6_idle_busy", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "bench timed out");
  end

endmodule
